hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage core. Collects operand-select bubble requests from decode, memory and multi-cycle busy signals, and execute-stage redirects. Produces per-stage hold (stall) and bubble-insert (flush) controls plus PC load controls. Owns the redirect-while-fetch-busy sequence: a latched target and a kill of the in-flight fetch. Sits beside the stage registers in the core top.

---
 rtl/common.sv | 7 +
 rtl/pipes.sv | 8 +
 rtl/sat_counter.sv | 28 ++
 rtl/hazard_ctrl.sv | 102 ++++++++++
 tb/tb_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/common.sv
// Core-wide widths and basic types shared by every pipeline block.
package common;
   localparam int XLEN        = 64;
   localparam int STALL_CNT_W = 32;

   typedef logic [XLEN-1:0] word_t;
endpackage : common

// File: rtl/pipes.sv
// Pipeline-control types shared between the stage registers and their controllers.
package pipes;
   // RUN: normal issue. KILL: waiting out a stale fetch after a redirect.
   typedef enum logic {
      RUN  = 1'b0,
      KILL = 1'b1
   } hz_state_t;
endpackage : pipes

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // NOTE: default first so every path assigns count_d and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: stage holds/bubbles, PC load control,
// and the redirect-while-fetch-busy kill sequence.
module hazard_ctrl
   import common::*;
   import pipes::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   bubble_a,
   input  logic                   bubble_b,
   input  logic                   i_busy,
   input  logic                   d_busy,
   input  logic                   ex_busy,
   input  logic                   redirect,
   input  word_t                  redirect_pc,
   output logic                   stall_f,
   output logic                   stall_d,
   output logic                   stall_e,
   output logic                   stall_m,
   output logic                   flush_d,
   output logic                   flush_e,
   output logic                   flush_m,
   output logic                   flush_w,
   output logic                   pc_we,
   output logic                   pc_redir,
   output word_t                  pc_target,
   output logic                   drop_fetch,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   hz_state_t state_q, state_d;
   word_t     pend_pc_q, pend_pc_d;

   logic g, b, r, kill;

   // A stall from M or E freezes everything younger, so it masks bubbles and redirects.
   assign g    = d_busy | ex_busy;
   assign b    = (bubble_a | bubble_b) & ~g;
   assign kill = (state_q == KILL);
   assign r    = redirect & ~g & ~kill;

   assign stall_m    = d_busy;
   assign flush_w    = d_busy;
   assign stall_e    = g;
   assign flush_m    = ex_busy & ~d_busy;
   // A redirect wins over a bubble: the younger instruction is wrong-path anyway.
   assign stall_d    = g | (b & ~r);
   assign flush_e    = ~g & (r | b);
   assign flush_d    = ~stall_d & (r | kill | i_busy);
   assign stall_f    = g | i_busy | (b & ~r) | kill;
   assign drop_fetch = kill;

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      pc_we     = 1'b0;
      pc_redir  = 1'b0;
      pc_target = pend_pc_q;
      unique case (state_q)
         RUN: begin
            if (r && !i_busy) begin
               pc_we     = 1'b1;
               pc_redir  = 1'b1;
               pc_target = redirect_pc;
            end else if (r) begin
               pend_pc_d = redirect_pc;
               state_d   = KILL;
            end else begin
               pc_we = ~stall_f;
            end
         end
         KILL: begin
            // The stale word returns this cycle and is dropped; load the target even under g.
            if (!i_busy) begin
               pc_we    = 1'b1;
               pc_redir = 1'b1;
               state_d  = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: pend_pc is a plain register, not a memory, so it is reset with the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_f),
      .count (stall_cycles)
   );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected control vectors are hand-derived.
module tb_hazard_ctrl;
   import common::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   bubble_a, bubble_b, i_busy, d_busy, ex_busy, redirect;
   word_t                  redirect_pc;
   logic                   stall_f, stall_d, stall_e, stall_m;
   logic                   flush_d, flush_e, flush_m, flush_w;
   logic                   pc_we, pc_redir, drop_fetch;
   word_t                  pc_target;
   logic [STALL_CNT_W-1:0] stall_cycles;

   int                     n_vec = 0;
   int                     n_bad = 0;
   logic [31:0]            exp_cnt = '0;

   // Control-vector layout: stall F D E M | flush D E M W | pc_we pc_redir drop_fetch
   localparam logic [10:0] IDLE = 11'b0000_0000_100;

   hazard_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .bubble_a     (bubble_a),
      .bubble_b     (bubble_b),
      .i_busy       (i_busy),
      .d_busy       (d_busy),
      .ex_busy      (ex_busy),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .stall_f      (stall_f),
      .stall_d      (stall_d),
      .stall_e      (stall_e),
      .stall_m      (stall_m),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .flush_m      (flush_m),
      .flush_w      (flush_w),
      .pc_we        (pc_we),
      .pc_redir     (pc_redir),
      .pc_target    (pc_target),
      .drop_fetch   (drop_fetch),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   // A redirect must never arrive while a fetch kill is in progress.
   always @(negedge clk)
      if (!reset) assert (!(redirect && drop_fetch)) else $error("redirect seen during fetch kill");

   function automatic logic [10:0] ctl();
      return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
              pc_we, pc_redir, drop_fetch};
   endfunction

   task automatic drive(input logic ba, input logic bb, input logic ib, input logic db,
                        input logic eb, input logic rd, input word_t rpc);
      bubble_a = ba; bubble_b = bb; i_busy = ib; d_busy = db;
      ex_busy = eb; redirect = rd; redirect_pc = rpc;
   endtask

   task automatic next();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, '0);
      #3;
      n_vec++;
      if (ctl() !== IDLE) begin
         n_bad++; $display("FAIL reset_ctl got %b want %b", ctl(), IDLE);
      end
      n_vec++;
      if (stall_cycles !== 32'd0) begin
         n_bad++; $display("FAIL reset_cnt got %h want %h", stall_cycles, 32'd0);
      end
      next();
      reset = 1'b0;
   endtask

   task automatic test_load_use();
      drive(1, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (ctl() !== 11'b1100_0100_000) begin
         n_bad++; $display("FAIL load_use_ctl got %b want %b", ctl(), 11'b1100_0100_000);
      end
      next();
      exp_cnt += 1;
      drive(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (stall_cycles !== exp_cnt) begin
         n_bad++; $display("FAIL load_use_cnt got %h want %h", stall_cycles, exp_cnt);
      end
      n_vec++;
      if (ctl() !== IDLE) begin
         n_bad++; $display("FAIL load_use_idle got %b want %b", ctl(), IDLE);
      end
      next();
   endtask

   task automatic test_redirect_idle();
      drive(0, 0, 0, 0, 0, 1, 64'h0000_0000_8000_0040);
      @(negedge clk);
      n_vec++;
      if (ctl() !== 11'b0000_1100_110) begin
         n_bad++; $display("FAIL redir_idle_ctl got %b want %b", ctl(), 11'b0000_1100_110);
      end
      n_vec++;
      if (pc_target !== 64'h0000_0000_8000_0040) begin
         n_bad++; $display("FAIL redir_idle_target got %h want %h", pc_target, 64'h8000_0040);
      end
      next();
      drive(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (ctl() !== IDLE) begin
         n_bad++; $display("FAIL redir_idle_after got %b want %b", ctl(), IDLE);
      end
      next();
   endtask

   task automatic test_redirect_busy();
      drive(0, 0, 1, 0, 0, 1, 64'h0000_0000_8000_0100);
      @(negedge clk);
      n_vec++;
      if (ctl() !== 11'b1000_1100_000) begin
         n_bad++; $display("FAIL redir_busy_c0 got %b want %b", ctl(), 11'b1000_1100_000);
      end
      next();
      exp_cnt += 1;
      drive(0, 0, 1, 0, 0, 0, 64'h0000_0000_dead_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (ctl() !== 11'b1000_1000_001) begin
            n_bad++; $display("FAIL redir_busy_kill%0d got %b want %b", i, ctl(), 11'b1000_1000_001);
         end
         next();
         exp_cnt += 1;
      end
      i_busy = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ctl() !== 11'b1000_1000_111) begin
         n_bad++; $display("FAIL redir_busy_release got %b want %b", ctl(), 11'b1000_1000_111);
      end
      n_vec++;
      if (pc_target !== 64'h0000_0000_8000_0100) begin
         n_bad++; $display("FAIL redir_busy_target got %h want %h", pc_target, 64'h8000_0100);
      end
      next();
      exp_cnt += 1;
      drive(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (ctl() !== IDLE) begin
         n_bad++; $display("FAIL redir_busy_run got %b want %b", ctl(), IDLE);
      end
      n_vec++;
      if (stall_cycles !== exp_cnt) begin
         n_bad++; $display("FAIL redir_busy_cnt got %h want %h", stall_cycles, exp_cnt);
      end
      next();
   endtask

   task automatic test_mem_stall();
      drive(0, 1, 0, 1, 0, 1, 64'h0000_0000_8000_0200);
      @(negedge clk);
      n_vec++;
      if (ctl() !== 11'b1111_0001_000) begin
         n_bad++; $display("FAIL mem_stall_ctl got %b want %b", ctl(), 11'b1111_0001_000);
      end
      next();
      exp_cnt += 1;
      drive(0, 0, 0, 1, 1, 0, '0);
      @(negedge clk);
      n_vec++;
      if (ctl() !== 11'b1111_0001_000) begin
         n_bad++; $display("FAIL mem_over_ex_ctl got %b want %b", ctl(), 11'b1111_0001_000);
      end
      next();
      exp_cnt += 1;
      drive(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (ctl() !== IDLE) begin
         n_bad++; $display("FAIL mem_stall_run got %b want %b", ctl(), IDLE);
      end
      next();
   endtask

   task automatic test_muldiv();
      drive(0, 0, 0, 0, 1, 0, '0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (ctl() !== 11'b1110_0010_000) begin
            n_bad++; $display("FAIL muldiv_c%0d got %b want %b", i, ctl(), 11'b1110_0010_000);
         end
         next();
         exp_cnt += 1;
      end
      drive(0, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (stall_cycles !== exp_cnt) begin
         n_bad++; $display("FAIL muldiv_cnt got %h want %h", stall_cycles, exp_cnt);
      end
      next();
   endtask

   task automatic test_reset_kill();
      drive(0, 0, 1, 0, 0, 1, 64'h0000_0000_0000_1234);
      next();
      exp_cnt += 1;
      drive(0, 0, 1, 0, 0, 0, '0);
      @(negedge clk);
      n_vec++;
      if (drop_fetch !== 1'b1) begin
         n_bad++; $display("FAIL kill_entered got %b want %b", drop_fetch, 1'b1);
      end
      n_vec++;
      if (stall_cycles !== exp_cnt) begin
         n_bad++; $display("FAIL kill_cnt got %h want %h", stall_cycles, exp_cnt);
      end
      #1 reset = 1'b1;
      #1;
      exp_cnt = '0;
      n_vec++;
      if (ctl() !== 11'b1000_1000_000) begin
         n_bad++; $display("FAIL kill_reset_ctl got %b want %b", ctl(), 11'b1000_1000_000);
      end
      n_vec++;
      if (stall_cycles !== exp_cnt) begin
         n_bad++; $display("FAIL kill_reset_cnt got %h want %h", stall_cycles, exp_cnt);
      end
      drive(0, 0, 0, 0, 0, 0, '0);
      next();
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ctl() !== IDLE) begin
         n_bad++; $display("FAIL kill_reset_idle got %b want %b", ctl(), IDLE);
      end
      next();
   endtask

   task automatic test_saturation();
      drive(1, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
      #1 release dut.u_stall_cnt.count_q;
      next();
      @(negedge clk);
      n_vec++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
         n_bad++; $display("FAIL sat_reach got %h want %h", stall_cycles, 32'hFFFF_FFFF);
      end
      next();
      next();
      @(negedge clk);
      n_vec++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
         n_bad++; $display("FAIL sat_hold got %h want %h", stall_cycles, 32'hFFFF_FFFF);
      end
      drive(0, 0, 0, 0, 0, 0, '0);
      next();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_redirect_idle();
      test_redirect_busy();
      test_mem_stall();
      test_muldiv();
      test_reset_kill();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule : tb_hazard_ctrl
